// File: rtl/serializer_pkg.sv
// serializer_pkg: shared FSM state type and count-width helper for stream_serializer
package serializer_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/stream_serializer_lane_select.sv
// lane_select: maps a beat index onto LANES buffer elements with keep mask and last-beat flag
module lane_select import serializer_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_COUNT  = 20,
  parameter int LANES      = 1,
  localparam int CW = cnt_w(MAX_COUNT),
  localparam int IW = MAX_COUNT > 1 ? $clog2(MAX_COUNT) : 1
) (
  input  logic [DATA_WIDTH-1:0] buffer [MAX_COUNT],
  input  logic [CW-1:0]         beat,
  input  logic [CW-1:0]         count,
  output logic [DATA_WIDTH-1:0] lanes [LANES],
  output logic [LANES-1:0]      keep,
  output logic                  last
);
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [31:0]   e;
    logic [IW-1:0] idx;
    assign e        = 32'(beat) * 32'(LANES) + 32'(j);
    assign idx      = e < 32'(MAX_COUNT) ? IW'(e) : '0;
    assign keep[j]  = e < 32'(count);
    assign lanes[j] = keep[j] ? buffer[idx] : '0;
  end
  assign last = 32'(beat) * 32'(LANES) + 32'(LANES) >= 32'(count);
endmodule

// File: rtl/stream_serializer.sv
// stream_serializer: captures a parallel vector and streams it out LANES elements per beat
module stream_serializer import serializer_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_COUNT  = 20,
  parameter int LANES      = 1,
  localparam int CW = cnt_w(MAX_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] parallel_in [MAX_COUNT],
  input  logic [CW-1:0]         i_count,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] serial_out [LANES],
  output logic [LANES-1:0]      o_keep,
  output logic                  o_last
);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] buffer [MAX_COUNT];
  logic [CW-1:0] count, beat, count_eff;
  logic send, last, in_hs, out_hs;
  assign send      = state == SEND;
  assign o_valid   = send;
  assign o_last    = send & last;
  assign i_ready   = send ? o_last & o_ready : 1'b1;
  assign in_hs     = i_valid & i_ready;
  assign out_hs    = o_valid & o_ready;
  assign count_eff = (i_count == '0 || i_count > CW'(MAX_COUNT)) ? CW'(MAX_COUNT) : i_count;
  always_comb state_nx = in_hs ? SEND : (out_hs && last) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      beat   <= '0;
      count  <= '0;
      buffer <= '{default: '0};
    end else begin
      state <= state_nx;
      if (in_hs) begin
        buffer <= parallel_in;
        count  <= count_eff;
        beat   <= '0;
      end else if (out_hs) begin
        beat <= beat + 1'b1;
      end
    end
  end
  // a zero count outside SEND blanks every lane and keep bit
  lane_select #(.DATA_WIDTH(DATA_WIDTH), .MAX_COUNT(MAX_COUNT), .LANES(LANES)) u_lane (
    .buffer(buffer),
    .beat(beat),
    .count(send ? count : '0),
    .lanes(serial_out),
    .keep(o_keep),
    .last(last)
  );
endmodule
